// File: rtl/dvi_tx_pkg.sv
// Shared types and constants for the DVI transmit timing generator:
// FSM state and raster region enums, the colour bar palette, and
// small decode helpers.
package dvi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RG_ACTIVE = 2'd0,
    RG_FP     = 2'd1,
    RG_SYNC   = 2'd2,
    RG_BP     = 2'd3
  } region_e;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  // Bar index to RGB colour, left to right across the active line.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = BAR_WHITE;
      3'd1:    c = BAR_YELLOW;
      3'd2:    c = BAR_CYAN;
      3'd3:    c = BAR_GREEN;
      3'd4:    c = BAR_MAGENTA;
      3'd5:    c = BAR_RED;
      3'd6:    c = BAR_BLUE;
      default: c = BAR_BLACK;
    endcase
    return c;
  endfunction

  // Classify a line/frame counter position: active, front porch, sync, back porch.
  function automatic region_e region_of(input int cnt, input int act,
                                        input int fp, input int sync);
    region_e r;
    if (cnt < act)                 r = RG_ACTIVE;
    else if (cnt < act + fp)       r = RG_FP;
    else if (cnt < act + fp + sync) r = RG_SYNC;
    else                           r = RG_BP;
    return r;
  endfunction

endpackage

// File: rtl/dvi_tx_bar_gen.sv
// Eight-bar colour pattern generator. A BAR_W down-counter and a 3-bit
// bar index walk across the active line; both reload at line start, so no
// divider is needed. colour_o is combinational for the current h position
// and is registered by the parent together with the sync decode.
// Optional: DVI_TX_TPG_SCROLL_EN makes the reload point a per-frame offset
// that advances by one pixel at each frame wrap, scrolling the bars left.
module dvi_tx_bar_gen
  import dvi_tx_pkg::*;
#(
  parameter int H_ACTIVE = 1920
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idle_i,
  input  logic        line_start_i,
  input  logic        active_i,
`ifdef DVI_TX_TPG_SCROLL_EN
  input  logic        frame_wrap_i,
`endif
  output logic [23:0] colour_o
);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int CW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BAR_W - 1);

  logic [2:0]    idx_q, cur_idx, load_idx;
  logic [CW-1:0] cnt_q, cur_cnt, load_cnt;

`ifdef DVI_TX_TPG_SCROLL_EN
  // The offset is kept as a (bar index, pixels left in bar) pair so it
  // loads straight into the bar counters; the 3-bit index wraps modulo 8
  // bars, which is modulo H_ACTIVE pixels.
  logic [2:0]    off_idx_q;
  logic [CW-1:0] off_cnt_q;

  // Scroll offset: cleared while idle, advanced one pixel per frame wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      off_idx_q <= 3'd0;
      off_cnt_q <= CNT_MAX;
    end else if (idle_i) begin
      off_idx_q <= 3'd0;
      off_cnt_q <= CNT_MAX;
    end else if (frame_wrap_i) begin
      if (off_cnt_q == '0) begin
        off_cnt_q <= CNT_MAX;
        off_idx_q <= off_idx_q + 3'd1;
      end else begin
        off_cnt_q <= off_cnt_q - 1'b1;
      end
    end
  end

  assign load_idx = off_idx_q;
  assign load_cnt = off_cnt_q;
`else
  assign load_idx = 3'd0;
  assign load_cnt = CNT_MAX;
`endif

  // At line start the load value applies to this very pixel.
  assign cur_idx  = line_start_i ? load_idx : idx_q;
  assign cur_cnt  = line_start_i ? load_cnt : cnt_q;
  assign colour_o = bar_colour(cur_idx);

  // Bar position for the next pixel; steps only across active pixels.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= 3'd0;
      cnt_q <= CNT_MAX;
    end else if (idle_i) begin
      idx_q <= 3'd0;
      cnt_q <= CNT_MAX;
    end else if (active_i) begin
      if (cur_cnt == '0) begin
        cnt_q <= CNT_MAX;
        idx_q <= cur_idx + 3'd1;
      end else begin
        cnt_q <= cur_cnt - 1'b1;
        idx_q <= cur_idx;
      end
    end
  end

endmodule

// File: rtl/dvi_tx_timing_gen.sv
// DVI raster timing generator with colour bar test pattern.
// A run/stop FSM (IDLE/RUN/DRAIN) starts output at (0,0) and only stops on a
// frame wrap, so a partial frame is never emitted. Outputs are registered
// one cycle after the counters they decode; busy reflects the state register.
// Optional: DVI_TX_TPG_SCROLL_EN scrolls the bars one pixel left per frame.
module dvi_tx_timing_gen
  import dvi_tx_pkg::*;
#(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        run,
  output logic        den,
  output logic        hsync,
  output logic        vsync,
  output logic [23:0] pixel_data,
  output logic        frame_start,
  output logic        busy
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  state_e        state_q;
  logic [HW-1:0] h_cnt_q;
  logic [VW-1:0] v_cnt_q;

  logic          running, h_wrap, v_wrap, frame_wrap, line_start, h_act;
  region_e       h_reg, v_reg;
  logic [23:0]   colour;

  logic          den_d, hsync_d, vsync_d, frame_start_d;
  logic [23:0]   pixel_data_d;

  logic          den_q, hsync_q, vsync_q, frame_start_q;
  logic [23:0]   pixel_data_q;

  assign running    = (state_q != ST_IDLE);
  assign h_wrap     = (int'(h_cnt_q) == H_TOTAL - 1);
  assign v_wrap     = (int'(v_cnt_q) == V_TOTAL - 1);
  assign frame_wrap = h_wrap && v_wrap;
  assign h_reg      = region_of(int'(h_cnt_q), H_ACTIVE, H_FP, H_SYNC);
  assign v_reg      = region_of(int'(v_cnt_q), V_ACTIVE, V_FP, V_SYNC);
  assign line_start = running && (h_cnt_q == '0);
  assign h_act      = running && (h_reg == RG_ACTIVE);

  // Run/stop FSM and raster counters; counters hold at (0,0) while idle.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          h_cnt_q <= '0;
          v_cnt_q <= '0;
          if (run) state_q <= ST_RUN;
        end
        ST_RUN: begin
          // Stop requested exactly on the wrap: the frame is already complete.
          if (!run) state_q <= frame_wrap ? ST_IDLE : ST_DRAIN;
        end
        ST_DRAIN: begin
          if (run)             state_q <= ST_RUN;
          else if (frame_wrap) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      if (running) begin
        h_cnt_q <= h_wrap ? '0 : h_cnt_q + 1'b1;
        if (h_wrap) v_cnt_q <= v_wrap ? '0 : v_cnt_q + 1'b1;
      end
    end
  end

  dvi_tx_bar_gen #(
    .H_ACTIVE     (H_ACTIVE)
  ) u_bar_gen (
    .clk_i        (pixel_clock),
    .rst_i        (reset),
    .idle_i       (!running),
    .line_start_i (line_start),
    .active_i     (h_act),
`ifdef DVI_TX_TPG_SCROLL_EN
    .frame_wrap_i (frame_wrap),
`endif
    .colour_o     (colour)
  );

  // Decode the current counter position into next-cycle pin values.
  always_comb begin
    den_d         = running && (h_reg == RG_ACTIVE) && (v_reg == RG_ACTIVE);
    hsync_d       = (running && (h_reg == RG_SYNC)) ? HS_POL : ~HS_POL;
    vsync_d       = (running && (v_reg == RG_SYNC)) ? VS_POL : ~VS_POL;
    frame_start_d = running && (h_cnt_q == '0) && (v_cnt_q == '0);
    pixel_data_d  = den_d ? colour : 24'h000000;
  end

  // Output registers keep den, syncs and pixel data mutually aligned.
  always_ff @(posedge pixel_clock or posedge reset) begin
    if (reset) begin
      den_q         <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      frame_start_q <= 1'b0;
      pixel_data_q  <= 24'h000000;
    end else begin
      den_q         <= den_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      pixel_data_q  <= pixel_data_d;
    end
  end

  assign den         = den_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;
  assign pixel_data  = pixel_data_q;
  assign busy        = running;

endmodule

// File: tb/tb_dvi_tx_timing_gen.sv
// Bench for dvi_tx_timing_gen with a small raster: 16+2+3+3 = 24 pixels per
// line, 4+1+2+1 = 8 lines, 192 cycles per frame, bar width 2 pixels.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dvi_tx_timing_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        den, hsync, vsync, frame_start, busy;
  logic [23:0] pixel_data;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] bar_tab[8];

  typedef struct {
    int          k;
    logic        den;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] pix;
  } vec_t;
  vec_t tbl[22];

  dvi_tx_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b1)
  ) dut (
    .pixel_clock (clk),
    .reset       (reset),
    .run         (run),
    .den         (den),
    .hsync       (hsync),
    .vsync       (vsync),
    .pixel_data  (pixel_data),
    .frame_start (frame_start),
    .busy        (busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Wait (bounded) for frame_start at a falling-edge sample; lat counts edges waited.
  task automatic wait_fs(input int max, output int lat);
    lat = 0;
    while (frame_start !== 1'b1 && lat < max) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic set_vec(input int i, input int k, input logic d, input logic h,
                         input logic v, input logic f, input logic [23:0] p);
    tbl[i].k = k; tbl[i].den = d; tbl[i].hs = h; tbl[i].vs = v;
    tbl[i].fs = f; tbl[i].pix = p;
  endtask

  initial begin
    int lat, den_cnt, hs_cnt, vs_cnt, pix_bad, busy_low, bad, fs_cnt;
    logic [23:0] exp_pix;

    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00;
    bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000;
    bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;

    // k = sample index after frame_start; h = k % 24, v = k / 24.
    set_vec(0,    0, 1, 0, 0, 1, 24'hFFFFFF);
    set_vec(1,    1, 1, 0, 0, 0, 24'hFFFFFF);
    set_vec(2,    2, 1, 0, 0, 0, 24'hFFFF00);
    set_vec(3,    5, 1, 0, 0, 0, 24'h00FFFF);
    set_vec(4,    7, 1, 0, 0, 0, 24'h00FF00);
    set_vec(5,    9, 1, 0, 0, 0, 24'hFF00FF);
    set_vec(6,   11, 1, 0, 0, 0, 24'hFF0000);
    set_vec(7,   13, 1, 0, 0, 0, 24'h0000FF);
    set_vec(8,   15, 1, 0, 0, 0, 24'h000000);
    set_vec(9,   16, 0, 0, 0, 0, 24'h000000);
    set_vec(10,  17, 0, 0, 0, 0, 24'h000000);
    set_vec(11,  18, 0, 1, 0, 0, 24'h000000);
    set_vec(12,  20, 0, 1, 0, 0, 24'h000000);
    set_vec(13,  21, 0, 0, 0, 0, 24'h000000);
    set_vec(14,  24, 1, 0, 0, 0, 24'hFFFFFF);
    set_vec(15,  87, 1, 0, 0, 0, 24'h000000);
    set_vec(16,  90, 0, 1, 0, 0, 24'h000000);
    set_vec(17, 119, 0, 0, 0, 0, 24'h000000);
    set_vec(18, 120, 0, 0, 1, 0, 24'h000000);
    set_vec(19, 138, 0, 1, 1, 0, 24'h000000);
    set_vec(20, 167, 0, 0, 1, 0, 24'h000000);
    set_vec(21, 168, 0, 0, 0, 0, 24'h000000);

    // Reset held
    reset = 1'b1;
    run   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {3'b0, den, hsync, vsync, frame_start, busy, pixel_data}, 32'h0);

    // Released with run=0: idle for 500 cycles
    reset = 1'b0;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (den || hsync || vsync || frame_start || busy || pixel_data != 24'h0) bad++;
    end
    chk("idle_500", bad, 0);

    // Expected active pixels for frame 1: each bar twice, on all 4 lines
    for (int l = 0; l < 4; l++)
      for (int b = 0; b < 8; b++) begin
        exp_q.push_back(bar_tab[b]);
        exp_q.push_back(bar_tab[b]);
      end

    // Start: busy after one edge, frame_start registered one edge later
    run = 1'b1;
    @(negedge clk);
    chk("busy_rise", {31'b0, busy}, 1);
    wait_fs(10, lat);
    chk("start_latency", lat, 1);

    // Frame 1 sweep
    den_cnt = 0; hs_cnt = 0; vs_cnt = 0; pix_bad = 0; busy_low = 0;
    for (int k = 0; k < 192; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < 22; i++)
        if (tbl[i].k == k)
          chk($sformatf("vec_k%0d", k), {4'b0, den, hsync, vsync, frame_start, pixel_data},
              {4'b0, tbl[i].den, tbl[i].hs, tbl[i].vs, tbl[i].fs, tbl[i].pix});
      if (den) begin
        den_cnt++;
        if (exp_q.size() == 0) chk("pix_q_empty", {8'b0, pixel_data}, 32'hFFFFFFFF);
        else begin
          exp_pix = exp_q.pop_front();
          chk($sformatf("pix_seq_k%0d", k), {8'b0, pixel_data}, {8'b0, exp_pix});
        end
      end else if (pixel_data != 24'h0) pix_bad++;
      if (hsync) hs_cnt++;
      if (vsync) vs_cnt++;
      if (!busy) busy_low++;
    end
    chk("den_count", den_cnt, 64);
    chk("hsync_count", hs_cnt, 24);
    chk("vsync_count", vs_cnt, 48);
    chk("pix_zero_blank", pix_bad, 0);
    chk("busy_frame1", busy_low, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    // Frame 2: period, bar pattern at line 0, run dropped after line 2 begins
    @(negedge clk);
    chk("frame_period", {31'b0, frame_start}, 1);
    den_cnt = 0;
    for (int j = 0; j < 192; j++) begin
      if (j > 0) @(negedge clk);
      if (den) den_cnt++;
`ifdef DVI_TX_TPG_SCROLL_EN
      if (j == 0)  chk("scroll_j0",  {8'b0, pixel_data}, 32'hFFFFFF);
      if (j == 1)  chk("scroll_j1",  {8'b0, pixel_data}, 32'hFFFF00);
      if (j == 2)  chk("scroll_j2",  {8'b0, pixel_data}, 32'hFFFF00);
      if (j == 3)  chk("scroll_j3",  {8'b0, pixel_data}, 32'h00FFFF);
      if (j == 15) chk("scroll_j15", {8'b0, pixel_data}, 32'hFFFFFF);
`else
      if (j == 1)  chk("static_j1",  {8'b0, pixel_data}, 32'hFFFFFF);
      if (j == 3)  chk("static_j3",  {8'b0, pixel_data}, 32'hFFFF00);
      if (j == 15) chk("static_j15", {8'b0, pixel_data}, 32'h000000);
`endif
      if (j == 48) run = 1'b0;
      if (j == 190) chk("drain_busy_j190", {31'b0, busy}, 1);
      if (j == 191) chk("drain_busy_j191", {31'b0, busy}, 0);
    end
    chk("drain_full_frame", den_cnt, 64);
    fs_cnt = 0; bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_start) fs_cnt++;
      if (den || busy) bad++;
    end
    chk("no_second_fs", fs_cnt, 0);
    chk("idle_after_drain", bad, 0);

    // Run re-raised during drain: next frame follows seamlessly
    run = 1'b1;
    @(negedge clk);
    wait_fs(10, lat);
    chk("restart_latency", lat, 1);
    busy_low = 0; den_cnt = 0;
    for (int j = 0; j < 192; j++) begin
      if (j > 0) @(negedge clk);
      if (!busy) busy_low++;
      if (den) den_cnt++;
      if (j == 100) run = 1'b0;
      if (j == 150) run = 1'b1;
    end
    chk("reraise_busy", busy_low, 0);
    chk("reraise_den", den_cnt, 64);
    @(negedge clk);
    chk("seamless_fs", {31'b0, frame_start}, 1);

    // run dropped so it is sampled on the wrap cycle: straight to idle
    for (int j = 1; j <= 190; j++) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("wrap_stop_busy", {31'b0, busy}, 0);
    @(negedge clk);
    chk("wrap_stop_no_fs", {30'b0, frame_start, busy}, 0);

    // Reset asserted mid-line while den=1: outputs idle without a clock edge
    run = 1'b1;
    @(negedge clk);
    wait_fs(10, lat);
    chk("third_start", lat, 1);
    repeat (5) @(negedge clk);
    chk("pre_reset_den", {31'b0, den}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset", {3'b0, den, hsync, vsync, frame_start, busy, pixel_data}, 32'h0);
    @(negedge clk);
    run   = 1'b0;
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (den || hsync || vsync || frame_start || busy || pixel_data != 24'h0) bad++;
    end
    chk("idle_after_reset", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
